// File: rtl/nibble_add_seq.sv
// Multi-cycle wide adder/subtractor built around a registered 4-bit slice.
// Processes one nibble per clock, LSB first, chaining the carry between slices.
module nibble_add_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_sub,
  input  logic         req_cin,
  input  logic [W-1:0] req_x,
  input  logic [W-1:0] req_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_zero,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           zero_q, zero_d;
  logic [4:0]     slice;
  logic           last;

  assign last = (idx_q == IW'(NIBBLES - 1));

  // Slice adder: selected nibbles of x and effective y plus chained carry.
  always_comb begin
    slice = {1'b0, x_q[{idx_q, 2'b00} +: 4]}
          + {1'b0, y_q[{idx_q, 2'b00} +: 4]}
          + {4'd0, carry_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_sub ? ~req_y : req_y;
          carry_d = req_sub ? 1'b1 : req_cin;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice[3:0];
        carry_d = slice[4];
        idx_d   = idx_q + 1'b1;
        if (last) begin
          idx_d   = '0;
          cout_d  = slice[4];
          zero_d  = (sum_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_zero  = zero_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed self-checking bench for nibble_add_seq.
// Vectors carry hand-computed sums, carries and zero flags.
module tb_nibble_add_seq;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_sub;
  logic         req_cin;
  logic [W-1:0] req_x;
  logic [W-1:0] req_y;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_cin   (req_cin),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; optionally complete the response handshake.
  task automatic run_op(input string tag,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sub, input logic cin,
                        input logic [W-1:0] es, input logic ec,
                        input logic ez, input bit release_rsp);
    int n;
    req_x = x;
    req_y = y;
    req_sub = sub;
    req_cin = cin;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(NIBBLES));
    chk({tag, ".sum"}, 32'(rsp_sum), 32'(es));
    chk({tag, ".cout"}, 32'(rsp_cout), 32'(ec));
    chk({tag, ".zero"}, 32'(rsp_zero), 32'(ez));
    if (release_rsp) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, ".vdrop"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".rdyback"}, 32'(req_ready), 32'd1);
    end
  endtask

  logic [W-1:0] bx [3];
  logic [W-1:0] by [3];
  logic         bs [3];
  logic [W-1:0] bes [3];
  logic         bec [3];

  initial begin
    int k;
    int rcnt;
    int last_cyc;
    rst = 1'b1;
    req_valid = 1'b0;
    req_sub = 1'b0;
    req_cin = 1'b0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.sum", 32'(rsp_sum), 32'd0);
    chk("rst.cout", 32'(rsp_cout), 32'd0);
    chk("rst.zero", 32'(rsp_zero), 32'd0);
    rst = 1'b0;
    tick();

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
    run_op("cin", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1);
    run_op("sub57", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
    run_op("sub75", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1);

    // Backpressure with noisy request inputs.
    run_op("bp", 16'h0A0B, 16'h0102, 1'b0, 1'b0, 16'h0B0D, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      req_valid = ~req_valid;
      req_x = 16'(i * 16'h1357);
      req_y = 16'(i * 16'h2468);
      tick();
      chk("bp.valid", 32'(rsp_valid), 32'd1);
      chk("bp.sum", 32'(rsp_sum), 32'h0B0D);
      chk("bp.cout", 32'(rsp_cout), 32'd0);
      chk("bp.ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp.rdyback", 32'(req_ready), 32'd1);
    chk("bp.vdrop", 32'(rsp_valid), 32'd0);
    chk("bp.sumhold", 32'(rsp_sum), 32'h0B0D);

    // Abort at CALC idx=2.
    req_x = 16'h1111;
    req_y = 16'h2222;
    req_sub = 1'b0;
    req_cin = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("abort.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.valid", 32'(rsp_valid), 32'd0);
    chk("abort.sum", 32'(rsp_sum), 32'd0);
    chk("abort.ready", 32'(req_ready), 32'd1);
    tick();
    chk("abort.noresp", 32'(rsp_valid), 32'd0);
    run_op("post", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1);

    // Back-to-back stream.
    bx[0] = 16'h1111; by[0] = 16'h2222; bs[0] = 1'b0;
    bes[0] = 16'h3333; bec[0] = 1'b0;
    bx[1] = 16'h8000; by[1] = 16'h8000; bs[1] = 1'b0;
    bes[1] = 16'h0000; bec[1] = 1'b1;
    bx[2] = 16'h0100; by[2] = 16'h0001; bs[2] = 1'b1;
    bes[2] = 16'h00FF; bec[2] = 1'b1;
    k = 0;
    rcnt = 0;
    last_cyc = -1;
    req_x = bx[0];
    req_y = by[0];
    req_sub = bs[0];
    req_cin = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bit acc;
      acc = req_ready && req_valid;
      tick();
      if (acc) begin
        k++;
        if (k < 3) begin
          req_x = bx[k];
          req_y = by[k];
          req_sub = bs[k];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (rcnt < 3) begin
          chk("b2b.sum", 32'(rsp_sum), 32'(bes[rcnt]));
          chk("b2b.cout", 32'(rsp_cout), 32'(bec[rcnt]));
          if (last_cyc >= 0)
            chk("b2b.period", 32'(c - last_cyc), 32'(NIBBLES + 2));
        end
        last_cyc = c;
        rcnt++;
      end
    end
    rsp_ready = 1'b0;
    chk("b2b.count", 32'(rcnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
